fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
- Program-counter and redirect controller for the fetch stage, directly downstream of branch control.
- Consumes the single-bit PCSrc redirect decision plus the resolved target address, and holds the architectural fetch PC.
- Sequences the PC through normal increment, stall, deferred redirect and halt.
- Drives the instruction-memory address and the front-end flush signal.

Parameters:
PC_WIDTH, 16, width of PC and target buses
RESET_PC, 16'h0000, PC value loaded on reset
INSTR_BYTES, 2, byte increment per sequential fetch
TRAP_VECTOR, 16'h0002, PC loaded on misaligned redirect (used only with FETCH_ALIGN_CHECK_EN)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
PCSrc  in  1  redirect request from branch control (branch taken / jump / PC-immediate)
Target  in  PC_WIDTH  redirect target, valid when PCSrc=1
Stall  in  1  hazard stall; hold PC, no new fetch
Halt  in  1  HALT instruction decoded, valid only when PCSrc=0
PC  out  PC_WIDTH  current fetch address to instruction memory
PCPlus  out  PC_WIDTH  PC + INSTR_BYTES, combinational from PC, for link/next-PC use
InstrValid  out  1  fetch in this cycle is valid
Flush  out  1  one-cycle pulse: squash younger IF/ID contents
Halted  out  1  core halted
Misaligned  out  1  one-cycle pulse on trapped redirect (0 when feature disabled)

Behaviour:
- Reset is synchronous: when rst_n=0 at a rising edge, the block sets PC=RESET_PC, state=RUN, pend_valid=0, Flush=0, Halted=0 and Misaligned=0. Reset overrides all other inputs, including in HALTED and with a redirect pending.
- State register has two states: RUN and HALTED. There is also a pending-redirect register: pend_valid (1 bit) and pend_target (PC_WIDTH).
- In RUN, each cycle is evaluated in this priority order:
  1. PCSrc=1 and Stall=0: PC<=Target, Flush<=1 for the next cycle, pend_valid<=0. Any pending redirect is discarded; the newer redirect wins.
  2. PCSrc=1 and Stall=1: pend_target<=Target, pend_valid<=1, PC held, Flush=0. A later PCSrc during the same stall overwrites pend_target.
  3. pend_valid=1 and Stall=0: PC<=pend_target, pend_valid<=0, Flush<=1.
  4. Halt=1 (PCSrc=0, no pending redirect): state<=HALTED, PC held. This applies regardless of Stall.
  5. Stall=1: PC held.
  6. Otherwise: PC<=PC+INSTR_BYTES, wrapping modulo 2^PC_WIDTH (0xFFFE -> 0x0000 at default width).
- Halt in the same cycle as PCSrc is ignored, because it came from a wrong-path instruction.
- Halt while pend_valid=1 is ignored.
- Flush is registered: high for exactly one cycle following the cycle in which the redirect is applied. Back-to-back redirects give back-to-back Flush.
- InstrValid = (state==RUN) & ~Stall & ~pend_valid. It is 0 while a deferred redirect waits, so no wrong-path fetch is issued.
- HALTED:
  - PC frozen, InstrValid=0, Halted=1.
  - PCSrc, Stall and Halt are ignored.
  - The only exit is reset.
- PCPlus is always PC+INSTR_BYTES, truncated to PC_WIDTH.
- Latency: redirect-to-new-PC is 1 cycle when unstalled, or 1 cycle after Stall deasserts when deferred.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect (direct or deferred) with Target[0]=1 loads PC<=TRAP_VECTOR instead of the target.
  - Misaligned pulses high for one cycle, coincident with Flush.
  - Sequential increment is unaffected.
- Undefined:
  - Target[0] is forced to 0 on load.
  - Misaligned is tied to 0.
  - No trap logic is present.

Test Plan:
- Reset then 4 free-running cycles -> PC 0x0000,0x0002,0x0004,0x0006. InstrValid=1, Flush=0 throughout.
- At PC=0x0010, PCSrc=1 with Target=0x0040 -> next PC=0x0040, Flush=1 for one cycle, then PC=0x0042.
- Stall=1 for 3 cycles with PCSrc=1, Target=0x0100 in the first stall cycle, and PCSrc=1, Target=0x0200 in the second:
  - PC held and InstrValid=0 during the stall.
  - On the first unstalled cycle, PC becomes 0x0200 and Flush pulses once.
- Halt=1 together with PCSrc=1 (Target=0x0080) -> PC=0x0080, Halted=0. Later Halt alone -> Halted=1, PC frozen; PCSrc pulses ignored; rst_n=0 for one edge -> PC=0x0000, Halted=0.
- PC=0xFFFC free-running -> 0xFFFE, then 0x0000 (wrap).
- FETCH_ALIGN_CHECK_EN defined, PCSrc=1 with Target=0x0031 -> PC=0x0002, Misaligned=1 and Flush=1 for one cycle. Undefined -> PC=0x0030, Misaligned=0.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage program counter and redirect controller: increment, stall, deferred redirect, halt.
// Optional misaligned-redirect trap is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_pc_ctrl #(
   parameter int                  PC_WIDTH    = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter int                  INSTR_BYTES = 2,
   parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = PC_WIDTH'(2)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                PCSrc,
   input  logic [PC_WIDTH-1:0] Target,
   input  logic                Stall,
   input  logic                Halt,
   output logic [PC_WIDTH-1:0] PC,
   output logic [PC_WIDTH-1:0] PCPlus,
   output logic                InstrValid,
   output logic                Flush,
   output logic                Halted,
   output logic                Misaligned
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                pend_valid_q, pend_valid_d;
   logic [PC_WIDTH-1:0] pend_target_q, pend_target_d;
   logic                flush_q, flush_d;
   logic                misal_q, misal_d;
   logic [PC_WIDTH-1:0] pc_plus;

   function automatic logic [PC_WIDTH-1:0] redirect_pc(input logic [PC_WIDTH-1:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
      return t[0] ? TRAP_VECTOR : t;
`else
      return t & ~PC_WIDTH'(1);
`endif
   endfunction

   function automatic logic redirect_trap(input logic [PC_WIDTH-1:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
      return t[0];
`else
      return 1'b0 & t[0];
`endif
   endfunction

   assign pc_plus = pc_q + PC_WIDTH'(INSTR_BYTES);

   // Priority: live redirect > deferred redirect > halt > stall > increment.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      flush_d       = 1'b0;
      misal_d       = 1'b0;
      if (state_q == RUN) begin
         if (PCSrc && !Stall) begin
            pc_d         = redirect_pc(Target);
            misal_d      = redirect_trap(Target);
            flush_d      = 1'b1;
            pend_valid_d = 1'b0;
         end else if (PCSrc) begin
            pend_target_d = Target;
            pend_valid_d  = 1'b1;
         end else if (pend_valid_q && !Stall) begin
            pc_d         = redirect_pc(pend_target_q);
            misal_d      = redirect_trap(pend_target_q);
            flush_d      = 1'b1;
            pend_valid_d = 1'b0;
         end else if (Halt && !pend_valid_q) begin
            state_d = HALTED;
         end else if (!Stall) begin
            pc_d = pc_plus;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= RUN;
         pc_q         <= RESET_PC;
         pend_valid_q <= 1'b0;
         flush_q      <= 1'b0;
         misal_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_valid_q <= pend_valid_d;
         flush_q      <= flush_d;
         misal_q      <= misal_d;
      end
   end

   // Target holding register is only meaningful while pend_valid_q is set.
   always_ff @(posedge clk) begin
      pend_target_q <= pend_target_d;
   end

   assign PC         = pc_q;
   assign PCPlus     = pc_plus;
   assign InstrValid = (state_q == RUN) & ~Stall & ~pend_valid_q;
   assign Flush      = flush_q;
   assign Halted     = (state_q == HALTED);
   assign Misaligned = misal_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: stimulus pushes expected per-cycle outputs, monitor pops and compares.
module tb_fetch_pc_ctrl;

   logic        clk;
   logic        rst_n;
   logic        PCSrc;
   logic [15:0] Target;
   logic        Stall;
   logic        Halt;
   logic [15:0] PC;
   logic [15:0] PCPlus;
   logic        InstrValid;
   logic        Flush;
   logic        Halted;
   logic        Misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
   localparam logic [15:0] MIS_PC  = 16'h0002;
   localparam logic        MIS_BIT = 1'b1;
`else
   localparam logic [15:0] MIS_PC  = 16'h0030;
   localparam logic        MIS_BIT = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] pc;
      logic        iv;
      logic        fl;
      logic        hl;
      logic        ms;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nerr = 0;

   fetch_pc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .Target(Target), .Stall(Stall), .Halt(Halt),
      .PC(PC), .PCPlus(PCPlus), .InstrValid(InstrValid), .Flush(Flush), .Halted(Halted),
      .Misaligned(Misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exv);
      nvec++;
      if (act !== exv) begin
         nerr++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exv);
      end
   endtask

   // Monitor: samples mid-low-phase, after inputs have settled, before the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            cmp("PC", PC, e.pc);
            cmp("PCPlus", PCPlus, e.pc + 16'd2);
            cmp("InstrValid", {15'd0, InstrValid}, {15'd0, e.iv});
            cmp("Flush", {15'd0, Flush}, {15'd0, e.fl});
            cmp("Halted", {15'd0, Halted}, {15'd0, e.hl});
            cmp("Misaligned", {15'd0, Misaligned}, {15'd0, e.ms});
         end
      end
   end

   // Drive one cycle of inputs; optionally queue the outputs expected during that cycle.
   task automatic step(input logic rn, input logic pcs, input logic [15:0] tg,
                       input logic st, input logic hl, input logic chk,
                       input logic [15:0] epc, input logic eiv, input logic efl,
                       input logic ehl, input logic ems);
      exp_t e;
      @(negedge clk);
      rst_n  = rn;
      PCSrc  = pcs;
      Target = tg;
      Stall  = st;
      Halt   = hl;
      if (chk) begin
         e = '{pc: epc, iv: eiv, fl: efl, hl: ehl, ms: ems};
         q.push_back(e);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; PCSrc = 1'b0; Target = '0; Stall = 1'b0; Halt = 1'b0;
      //   rn  pcs  tg        st  hl  chk epc       iv  fl  hl  ms
      step(0,  0,   16'h0000, 0,  0,  0,  16'h0000, 1,  0,  0,  0);
      step(0,  0,   16'h0000, 0,  0,  1,  16'h0000, 1,  0,  0,  0);
      for (int i = 0; i < 8; i++)
         step(1, 0, 16'h0000, 0, 0, 1, 16'(2 * i), 1, 0, 0, 0);
      // Direct redirect at 0x0010
      step(1,  1,   16'h0040, 0,  0,  1,  16'h0010, 1,  0,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0040, 1,  1,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0042, 1,  0,  0,  0);
      // Deferred redirect, second target overwrites first
      step(1,  1,   16'h0100, 1,  0,  1,  16'h0044, 0,  0,  0,  0);
      step(1,  1,   16'h0200, 1,  0,  1,  16'h0044, 0,  0,  0,  0);
      step(1,  0,   16'h0000, 1,  0,  1,  16'h0044, 0,  0,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0044, 0,  0,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0200, 1,  1,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0202, 1,  0,  0,  0);
      // Halt with redirect is ignored; then real halt, ignored inputs, reset exit
      step(1,  1,   16'h0080, 0,  1,  1,  16'h0204, 1,  0,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0080, 1,  1,  0,  0);
      step(1,  0,   16'h0000, 0,  1,  1,  16'h0082, 1,  0,  0,  0);
      step(1,  1,   16'h0300, 0,  0,  1,  16'h0082, 0,  0,  1,  0);
      step(1,  0,   16'h0000, 1,  1,  1,  16'h0082, 0,  0,  1,  0);
      step(0,  1,   16'h0400, 0,  0,  1,  16'h0082, 0,  0,  1,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0000, 1,  0,  0,  0);
      // Halt while a deferred redirect is pending is ignored
      step(1,  1,   16'h0500, 1,  0,  1,  16'h0002, 0,  0,  0,  0);
      step(1,  0,   16'h0000, 0,  1,  1,  16'h0002, 0,  0,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0500, 1,  1,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0502, 1,  0,  0,  0);
      // Wrap-around
      step(1,  1,   16'hFFFC, 0,  0,  1,  16'h0504, 1,  0,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'hFFFC, 1,  1,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'hFFFE, 1,  0,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0000, 1,  0,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0002, 1,  0,  0,  0);
      // Back-to-back redirects give back-to-back Flush
      step(1,  1,   16'h0060, 0,  0,  1,  16'h0004, 1,  0,  0,  0);
      step(1,  1,   16'h0070, 0,  0,  1,  16'h0060, 1,  1,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0070, 1,  1,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  16'h0072, 1,  0,  0,  0);
      // Odd target
      step(1,  1,   16'h0031, 0,  0,  1,  16'h0074, 1,  0,  0,  0);
      step(1,  0,   16'h0000, 0,  0,  1,  MIS_PC,   1,  1,  0,  MIS_BIT);
      step(1,  0,   16'h0000, 0,  0,  1,  MIS_PC + 16'd2, 1, 0, 0, 0);
      step(1,  0,   16'h0000, 0,  0,  0,  16'h0000, 1,  0,  0,  0);
      repeat (3) @(negedge clk);
      nvec++;
      if (q.size() != 0) begin
         nerr++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
